// File: rtl/masked_encoder_if.sv
// Handshake bundle for masked_encoder: plaintext in, randomness in, shares out.
// The master modport is the encoder side; slave is the surrounding environment.
interface masked_encoder_if #(
    parameter int NUM_SHARES = 2,
    parameter int WIDTH      = 8
);
    logic [WIDTH-1:0]            in_data;
    logic                        in_data_valid;
    logic                        out_data_ready;
    logic [WIDTH-1:0]            in_rnd;
    logic                        in_rnd_valid;
    logic                        out_rnd_ready;
    logic [NUM_SHARES*WIDTH-1:0] out_shares;
    logic                        out_shares_valid;
    logic                        in_shares_ready;
    logic                        out_rnd_error;

    modport master (
        input  in_data, in_data_valid, in_rnd, in_rnd_valid, in_shares_ready,
        output out_data_ready, out_rnd_ready, out_shares, out_shares_valid, out_rnd_error
    );

    modport slave (
        output in_data, in_data_valid, in_rnd, in_rnd_valid, in_shares_ready,
        input  out_data_ready, out_rnd_ready, out_shares, out_shares_valid, out_rnd_error
    );
endinterface

// File: rtl/masked_encoder.sv
// Splits a plaintext word into NUM_SHARES Boolean shares using RNG beats.
// Optional zero-beat RNG check: define MASKED_ENCODER_RND_CHECK_EN.
module masked_encoder #(
    parameter int NUM_SHARES = 2,
    parameter int WIDTH      = 8
) (
    input  logic          in_clock,
    input  logic          in_reset_n,
    masked_encoder_if.master bus
);
    localparam int CW = $clog2(NUM_SHARES);
    localparam logic [CW-1:0] LAST = CW'(NUM_SHARES - 2);

    typedef enum logic [1:0] {IDLE, GATHER, OUTPUT} state_t;

    state_t state, state_nxt;

    logic data_rdy_q, rnd_rdy_q, vld_q;
    logic data_hs, rnd_hs, shares_hs, last_beat;

    logic [WIDTH-1:0]                        acc;
    logic [CW-1:0]                           cnt;
    logic [NUM_SHARES-2:0][WIDTH-1:0]        rnd_reg, rnd_nxt;
    logic [NUM_SHARES-1:0][WIDTH-1:0]        shares_q, shares_nxt;

    assign data_hs   = bus.in_data_valid   & data_rdy_q;
    assign rnd_hs    = bus.in_rnd_valid    & rnd_rdy_q;
    assign shares_hs = bus.in_shares_ready & vld_q;
    assign last_beat = rnd_hs && (cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_hs)   state_nxt = GATHER;
            GATHER:  if (last_beat) state_nxt = OUTPUT;
            OUTPUT:  if (shares_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The beat arriving this cycle is folded in so the completing beat lands
    // straight in the share register without waiting a cycle.
    always_comb begin
        rnd_nxt = rnd_reg;
        for (int i = 0; i < NUM_SHARES - 1; i++)
            if (cnt == CW'(i)) rnd_nxt[i] = bus.in_rnd;
    end

    assign shares_nxt = {acc ^ bus.in_rnd, rnd_nxt};

    // Handshake flags are registered from next state so outputs never see inputs.
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state      <= IDLE;
            data_rdy_q <= 1'b0;
            rnd_rdy_q  <= 1'b0;
            vld_q      <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            rnd_reg    <= '0;
            shares_q   <= '0;
        end else begin
            state      <= state_nxt;
            data_rdy_q <= (state_nxt == IDLE);
            rnd_rdy_q  <= (state_nxt == GATHER);
            vld_q      <= (state_nxt == OUTPUT);
            if (data_hs) begin
                acc <= bus.in_data;
                cnt <= '0;
            end
            if (rnd_hs) begin
                rnd_reg <= rnd_nxt;
                acc     <= acc ^ bus.in_rnd;
                cnt     <= cnt + 1'b1;
            end
            if (last_beat) shares_q <= shares_nxt;
        end
    end

    assign bus.out_data_ready   = data_rdy_q;
    assign bus.out_rnd_ready    = rnd_rdy_q;
    assign bus.out_shares_valid = vld_q;
    assign bus.out_shares       = shares_q;

`ifdef MASKED_ENCODER_RND_CHECK_EN
    logic err_q;
    always_ff @(posedge in_clock) begin
        if (!in_reset_n)                       err_q <= 1'b0;
        else if (rnd_hs && bus.in_rnd == '0)   err_q <= 1'b1;
    end
    assign bus.out_rnd_error = err_q;
`else
    assign bus.out_rnd_error = 1'b0;
`endif
endmodule

// File: tb/tb_masked_encoder.sv
// Directed and randomized checks of masked_encoder for 2 and 3 shares.
module tb_masked_encoder;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

`ifdef MASKED_ENCODER_RND_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    masked_encoder_if #(.NUM_SHARES(2), .WIDTH(8)) b2 ();
    masked_encoder_if #(.NUM_SHARES(3), .WIDTH(8)) b3 ();

    masked_encoder #(.NUM_SHARES(2), .WIDTH(8)) dut2 (
        .in_clock(clk), .in_reset_n(rst_n), .bus(b2.master));
    masked_encoder #(.NUM_SHARES(3), .WIDTH(8)) dut3 (
        .in_clock(clk), .in_reset_n(rst_n), .bus(b3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] d, r0, r1;
    logic [23:0] sh3;
    logic hs;
    int   budget;

    initial begin
        rst_n = 1'b0;
        b2.in_data = '0; b2.in_data_valid = 0; b2.in_rnd = '0; b2.in_rnd_valid = 0; b2.in_shares_ready = 0;
        b3.in_data = '0; b3.in_data_valid = 0; b3.in_rnd = '0; b3.in_rnd_valid = 0; b3.in_shares_ready = 0;
        tick();
        chk("rst_data_ready", b2.out_data_ready, 0);
        chk("rst_rnd_ready", b3.out_rnd_ready, 0);
        chk("rst_valid", b3.out_shares_valid, 0);
        chk("rst_shares", b3.out_shares, 0);
        chk("rst_err", b2.out_rnd_error, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready2", b2.out_data_ready, 1);
        chk("post_rst_ready3", b3.out_data_ready, 1);

        // N=2 basic: 0xA5 with rnd 0x3C -> {0x99, 0x3C}
        b2.in_data = 8'hA5; b2.in_data_valid = 1;
        b2.in_rnd = 8'h3C; b2.in_rnd_valid = 1; b2.in_shares_ready = 1;
        tick();
        b2.in_data_valid = 0;
        chk("n2_data_ready_low", b2.out_data_ready, 0);
        chk("n2_rnd_ready", b2.out_rnd_ready, 1);
        tick();
        b2.in_rnd_valid = 0;
        chk("n2_valid", b2.out_shares_valid, 1);
        chk("n2_shares", b2.out_shares, 16'h993C);
        tick();
        chk("n2_valid_drop", b2.out_shares_valid, 0);
        chk("n2_ready_back", b2.out_data_ready, 1);
        chk("n2_shares_hold", b2.out_shares, 16'h993C);

        // N=3 with RNG stall and consumer stall
        b3.in_data = 8'h0F; b3.in_data_valid = 1;
        tick();
        b3.in_data_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("n3_stall_rnd_ready", b3.out_rnd_ready, 1);
        chk("n3_stall_shares", b3.out_shares, 0);
        chk("n3_stall_valid", b3.out_shares_valid, 0);
        b3.in_rnd = 8'h11; b3.in_rnd_valid = 1;
        tick();
        b3.in_rnd = 8'h22;
        tick();
        b3.in_rnd_valid = 0;
        chk("n3_valid", b3.out_shares_valid, 1);
        chk("n3_shares", b3.out_shares, 24'h3C2211);
        sh3 = b3.out_shares;
        chk("n3_xor", sh3[7:0] ^ sh3[15:8] ^ sh3[23:16], 8'h0F);
        for (int i = 0; i < 5; i++) tick();
        chk("n3_hold_shares", b3.out_shares, 24'h3C2211);
        chk("n3_hold_valid", b3.out_shares_valid, 1);
        chk("n3_hold_data_ready", b3.out_data_ready, 0);
        b3.in_shares_ready = 1;
        tick();
        b3.in_shares_ready = 0;
        chk("n3_ready_back", b3.out_data_ready, 1);

        // Zero RNG beat on N=2
        b2.in_data = 8'h77; b2.in_data_valid = 1; b2.in_rnd = 8'h00; b2.in_rnd_valid = 1;
        tick();
        b2.in_data_valid = 0;
        tick();
        b2.in_rnd_valid = 0;
        chk("zero_shares", b2.out_shares, 16'h7700);
        chk("zero_err", b2.out_rnd_error, ERR_EXP);
        tick();
        b2.in_data = 8'h12; b2.in_data_valid = 1; b2.in_rnd = 8'h05; b2.in_rnd_valid = 1;
        tick();
        b2.in_data_valid = 0;
        tick();
        b2.in_rnd_valid = 0;
        chk("err_sticky_shares", b2.out_shares, 16'h1705);
        chk("err_sticky", b2.out_rnd_error, ERR_EXP);

        // Reset mid-GATHER on N=3 after one beat
        b3.in_data = 8'h33; b3.in_data_valid = 1;
        tick();
        b3.in_data_valid = 0; b3.in_rnd = 8'h44; b3.in_rnd_valid = 1;
        tick();
        b3.in_rnd_valid = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", b3.out_shares_valid, 0);
        chk("mid_rst_shares", b3.out_shares, 0);
        chk("mid_rst_rnd_ready", b3.out_rnd_ready, 0);
        chk("mid_rst_err", b2.out_rnd_error, 0);
        tick();
        chk("mid_rst_idle", b3.out_data_ready, 1);
        b3.in_data = 8'h5A; b3.in_data_valid = 1; b3.in_shares_ready = 1;
        tick();
        b3.in_data_valid = 0; b3.in_rnd = 8'h01; b3.in_rnd_valid = 1;
        tick();
        b3.in_rnd = 8'h02;
        tick();
        b3.in_rnd_valid = 0;
        chk("re_enc_shares", b3.out_shares, 24'h590201);
        tick();
        chk("re_enc_ready", b3.out_data_ready, 1);

        // Randomized N=3 with random gaps on every handshake
        for (int t = 0; t < 1000; t++) begin
            d = 8'($urandom); r0 = 8'($urandom); r1 = 8'($urandom);
            b3.in_data = d;
            hs = 0; budget = 0;
            while (!hs && budget < 50) begin
                b3.in_data_valid = 1'($urandom);
                hs = b3.in_data_valid & b3.out_data_ready;
                tick(); budget++;
            end
            b3.in_data_valid = 0;
            if (!hs) chk("rand_data_timeout", 0, 1);
            for (int k = 0; k < 2; k++) begin
                b3.in_rnd = (k == 0) ? r0 : r1;
                hs = 0; budget = 0;
                while (!hs && budget < 50) begin
                    b3.in_rnd_valid = 1'($urandom);
                    hs = b3.in_rnd_valid & b3.out_rnd_ready;
                    tick(); budget++;
                end
                b3.in_rnd_valid = 0;
                if (!hs) chk("rand_rnd_timeout", 0, 1);
            end
            hs = 0; budget = 0;
            while (!hs && budget < 50) begin
                b3.in_shares_ready = 1'($urandom);
                if (b3.out_data_ready) begin
                    chk("rand_ready_in_flight", b3.out_data_ready, 0);
                    break;
                end
                hs = b3.in_shares_ready & b3.out_shares_valid;
                if (hs) begin
                    sh3 = b3.out_shares;
                    chk("rand_shares", sh3, {d ^ r0 ^ r1, r1, r0});
                    chk("rand_xor", sh3[7:0] ^ sh3[15:8] ^ sh3[23:16], d);
                end
                tick(); budget++;
            end
            b3.in_shares_ready = 0;
            if (!hs) chk("rand_out_timeout", 0, 1);
        end
        tick();
        chk("rand_end_idle", b3.out_data_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/masked_encoder.md
# masked_encoder

Converts an unmasked WIDTH-bit value into NUM_SHARES Boolean shares, and is the entry point into the masked datapath that the sharewise gadgets (masked XOR, etc.) operate on. It accepts plaintext over a valid/ready handshake and pulls fresh randomness one WIDTH-bit beat at a time from the RNG over a second handshake. It presents the completed sharing on a third valid/ready port. Plaintext never appears unmasked on any output or on the share register.

## Interface
- NUM_SHARES, default 2, number of shares; legal values ≥ 2.
- WIDTH, default 8, bits per share.

Ports:
- in_clock  input  1  single clock; all logic on the rising edge.
- in_reset_n  input  1  reset; synchronous, active-low.
- in_data  input  WIDTH  plaintext value.
- in_data_valid  input  1  in_data is valid.
- out_data_ready  output  1  block accepts plaintext.
- in_rnd  input  WIDTH  one randomness beat.
- in_rnd_valid  input  1  in_rnd is valid.
- out_rnd_ready  output  1  block consumes a randomness beat.
- out_shares  output  NUM_SHARES*WIDTH  share i is at bits [i*WIDTH +: WIDTH].
- out_shares_valid  output  1  out_shares holds a complete sharing.
- in_shares_ready  input  1  consumer accepts out_shares.
- out_rnd_error  output  1  sticky flag for a stuck RNG (see Configuration).

## Operation
- A handshake occurs on any cycle where both valid and ready are high at the clock edge.
- The FSM has three states: IDLE, GATHER and OUTPUT.
- **IDLE**
  - out_data_ready=1. All other ready and valid outputs are 0.
  - On a data handshake: acc ← in_data, cnt ← 0, next state GATHER.
- **GATHER**
  - out_rnd_ready=1.
  - On each rnd handshake: rnd_reg[cnt] ← in_rnd, acc ← acc ^ in_rnd, cnt ← cnt+1.
  - On the handshake with cnt = NUM_SHARES-2, the sharing completes:
    - out_shares share i ← rnd_reg[i] for i < NUM_SHARES-1;
    - out_shares share NUM_SHARES-1 ← acc ^ in_rnd;
    - the share register is loaded in one cycle;
    - next state OUTPUT.
  - If in_rnd_valid is low, the FSM waits with no state change.
- **OUTPUT**
  - out_shares_valid=1. out_shares stays stable.
  - On in_shares_ready: next state IDLE.
- Invariant: the XOR of all shares in out_shares equals the accepted in_data.
- out_shares changes only on the completing GATHER beat or on reset. It holds its value after consumption.
- acc holds plaintext for only the cycle after capture when NUM_SHARES=2 and randomness is immediately available. This register is the only place plaintext is stored.
- Only one transaction is in flight. out_data_ready is low in GATHER and OUTPUT.
- cnt is ⌈log2(NUM_SHARES)⌉ bits wide. It never wraps, because it resets to 0 on every data capture.

## Timing
- Reset values: out_data_ready=0 during reset and 1 on the first cycle after deassertion (IDLE). out_rnd_ready=0, out_shares_valid=0, out_shares=0, out_rnd_error=0. acc, cnt and rnd_reg are 0.
- With the RNG always valid and the consumer always ready:
  - data handshake at cycle t;
  - rnd beats at t+1 … t+NUM_SHARES-1;
  - out_shares_valid at t+NUM_SHARES;
  - out_data_ready again at t+NUM_SHARES+1.
- Throughput is one sharing per NUM_SHARES+1 cycles.
- Reset asserted in any state: at the next edge the block returns to IDLE, the partial transaction is discarded, and all registers take their reset values.
- Ready and valid outputs are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- MASKED_ENCODER_RND_CHECK_EN defined: any accepted rnd beat equal to 0 sets out_rnd_error on the following cycle.
  - The flag is sticky until reset.
  - Encoding continues normally; the flag is report-only.
- Macro undefined: out_rnd_error is tied to 0 and no check logic is present.

## Test plan
- NUM_SHARES=2, WIDTH=8: in_data=0xA5, in_rnd=0x3C → out_shares share0=0x3C, share1=0x99. Valid 2 cycles after the data handshake.
- NUM_SHARES=3, WIDTH=8: in_data=0x0F, rnd beats 0x11, 0x22 → shares 0x11, 0x22, 0x3C. XOR of all shares equals 0x0F.
- Stalls:
  - in_rnd_valid held low for 4 cycles in GATHER → FSM waits and out_shares is unchanged;
  - in_shares_ready held low for 5 cycles → out_shares and valid stay stable, out_data_ready stays 0.
- Reset mid-GATHER (NUM_SHARES=3, after the first rnd beat) → next cycle: IDLE, out_shares=0, out_shares_valid=0. A new encode of 0x5A with rnd 0x01, 0x02 gives shares 0x01, 0x02, 0x59.
- With MASKED_ENCODER_RND_CHECK_EN: rnd beat 0x00 → out_rnd_error=1 the next cycle. It stays 1 across later transactions until in_reset_n=0. Without the macro it stays 0.
- Randomized: 1000 random data and rnd values with random valid/ready gaps → every sharing XORs to its input, and no handshake is lost or duplicated.
